// File: rtl/regfile_wb_pkg.sv
// Shared types for the register file writeback queue.
// The entry struct is sized from the default widths. If the top-level width
// parameters are overridden, these defaults must be changed to match.
package regfile_wb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;
    localparam int BE_WIDTH           = DEFAULT_DATA_WIDTH / 8;

    typedef struct packed {
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [DEFAULT_DATA_WIDTH-1:0] data;
        logic [BE_WIDTH-1:0]           be;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order FIFO of writeback entries.
// Besides the head, it exports every slot in age order (index 0 = oldest)
// with a valid bit, so the top level can run hazard and forwarding compares.
module regfile_wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t push_entry,
    output wb_entry_t head,
    output logic      full,
    output logic      empty,
    output wb_entry_t entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
            else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    // Age-ordered view of the slots for the hazard and forwarding logic.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries[k]     = mem[rd_ptr + PTR_W'(k)];
            entry_valid[k] = ((PTR_W+1)'(k) < count);
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue in front of the register file write port.
// Requests to register 0 or with no byte enables complete the handshake but
// are dropped. Accepted writes drain one per cycle into registered Rd_* outputs.
// Optional macro REGFILE_WB_FWD_EN adds the q_data/q_be forwarding outputs.
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    output logic                    wb_ready,
    input  logic [ADDR_WIDTH-1:0]   wb_addr,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    input  logic [DATA_WIDTH/8-1:0] wb_be,
    output logic [ADDR_WIDTH-1:0]   Rd_addr,
    output logic [DATA_WIDTH-1:0]   Rd_in,
    output logic [DATA_WIDTH/8-1:0] Rd_Byte_w_en,
    input  logic [ADDR_WIDTH-1:0]   q_addr,
    output logic                    q_hit,
    output logic                    empty
`ifdef REGFILE_WB_FWD_EN
    ,
    output logic [DATA_WIDTH-1:0]   q_data,
    output logic [DATA_WIDTH/8-1:0] q_be
`endif
);

    wb_entry_t        push_entry;
    wb_entry_t        head;
    wb_entry_t        fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic             fifo_full;
    logic             fifo_empty;
    logic             filtered;
    logic             push;
    logic             out_active;

    assign wb_ready   = !fifo_full;
    assign filtered   = (wb_addr == '0) || (wb_be == '0);
    assign push       = wb_valid && wb_ready && !filtered;
    assign push_entry = '{addr: wb_addr, data: wb_data, be: wb_be};
    assign out_active = (Rd_Byte_w_en != '0);
    assign empty      = fifo_empty && !out_active;

    regfile_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (!fifo_empty),
        .push_entry (push_entry),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .entries    (fifo_entries),
        .entry_valid(fifo_valid)
    );

    // Output stage: present the head for one cycle, otherwise drop the enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Rd_addr      <= '0;
            Rd_in        <= '0;
            Rd_Byte_w_en <= '0;
        end else if (!fifo_empty) begin
            Rd_addr      <= head.addr;
            Rd_in        <= head.data;
            Rd_Byte_w_en <= head.be;
        end else begin
            Rd_Byte_w_en <= '0;
        end
    end

    // RAW hazard flag over queued entries and the live output stage.
    always_comb begin
        q_hit = 1'b0;
        if (q_addr != '0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (fifo_valid[k] && fifo_entries[k].addr == q_addr) q_hit = 1'b1;
            end
            if (out_active && Rd_addr == q_addr) q_hit = 1'b1;
        end
    end

`ifdef REGFILE_WB_FWD_EN
    // Per-lane merge applied oldest first so that younger sources overwrite.
    always_comb begin
        q_data = '0;
        q_be   = '0;
        if (q_addr != '0) begin
            if (out_active && Rd_addr == q_addr) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (Rd_Byte_w_en[b]) begin
                        q_data[8*b +: 8] = Rd_in[8*b +: 8];
                        q_be[b]          = 1'b1;
                    end
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (fifo_valid[k] && fifo_entries[k].addr == q_addr) begin
                    for (int b = 0; b < DATA_WIDTH/8; b++) begin
                        if (fifo_entries[k].be[b]) begin
                            q_data[8*b +: 8] = fifo_entries[k].data[8*b +: 8];
                            q_be[b]          = 1'b1;
                        end
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue against a queue-based model.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [3:0]  wb_be = '0;
    logic [4:0]  Rd_addr;
    logic [31:0] Rd_in;
    logic [3:0]  Rd_Byte_w_en;
    logic [4:0]  q_addr = '0;
    logic        q_hit;
    logic        empty;
`ifdef REGFILE_WB_FWD_EN
    logic [31:0] q_data;
    logic [3:0]  q_be;
`endif

    int vectors = 0;
    int miscompares = 0;

    wr_t mq[$];
    wr_t out_w = '{addr: '0, data: '0, be: '0};

    regfile_wb_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_be       (wb_be),
        .Rd_addr     (Rd_addr),
        .Rd_in       (Rd_in),
        .Rd_Byte_w_en(Rd_Byte_w_en),
        .q_addr      (q_addr),
        .q_hit       (q_hit),
        .empty       (empty)
`ifdef REGFILE_WB_FWD_EN
        ,
        .q_data      (q_data),
        .q_be        (q_be)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return mq.size() < DEPTH;
    endfunction

    function automatic logic exp_empty();
        return (mq.size() == 0) && (out_w.be == 4'h0);
    endfunction

    function automatic logic exp_hit(input logic [4:0] qa);
        if (qa == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].addr == qa) return 1'b1;
        return (out_w.be != 4'h0) && (out_w.addr == qa);
    endfunction

    // Youngest source first; a lane is filled by the first source that enables it.
    function automatic void exp_fwd(input logic [4:0] qa, output logic [31:0] d, output logic [3:0] be);
        d = '0;
        be = '0;
        if (qa == 5'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr == qa)
                for (int b = 0; b < 4; b++)
                    if (mq[i].be[b] && !be[b]) begin be[b] = 1'b1; d[8*b +: 8] = mq[i].data[8*b +: 8]; end
        end
        if (out_w.be != 4'h0 && out_w.addr == qa)
            for (int b = 0; b < 4; b++)
                if (out_w.be[b] && !be[b]) begin be[b] = 1'b1; d[8*b +: 8] = out_w.data[8*b +: 8]; end
    endfunction

    task automatic drive_request(input logic v, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        wb_be    = be;
    endtask

    // Advance one clock edge and update the model; no checking here.
    task automatic tick();
        logic acc;
        wr_t  w;
        acc    = wb_valid && exp_ready();
        w.addr = wb_addr;
        w.data = wb_data;
        w.be   = wb_be;
        @(posedge clk);
        if (mq.size() > 0) out_w = mq.pop_front();
        else               out_w.be = 4'h0;
        if (acc && w.addr != 5'd0 && w.be != 4'h0) mq.push_back(w);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++; if (Rd_Byte_w_en !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_be: got %h want 0", Rd_Byte_w_en); end
        vectors++; if (Rd_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h want 0", Rd_addr); end
        vectors++; if (Rd_in !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 0", Rd_in); end
        vectors++; if (wb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", wb_ready); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty: got %b want 1", empty); end
        vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_qhit: got %b want 0", q_hit); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        drive_request(1'b1, 5'd1, 32'h48, 4'hF);
        #1;
        vectors++; if (wb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_ready: got %b want 1", wb_ready); end
        tick();
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
        vectors++; if (Rd_Byte_w_en !== 4'h0) begin miscompares++; $display("[TB] FAIL single_early: got %h want 0", Rd_Byte_w_en); end
        vectors++; if (empty !== 1'b0) begin miscompares++; $display("[TB] FAIL single_busy: got %b want 0", empty); end
        tick();
        vectors++; if (Rd_addr !== 5'd1) begin miscompares++; $display("[TB] FAIL single_addr: got %h want 1", Rd_addr); end
        vectors++; if (Rd_in !== 32'h48) begin miscompares++; $display("[TB] FAIL single_data: got %h want 48", Rd_in); end
        vectors++; if (Rd_Byte_w_en !== 4'hF) begin miscompares++; $display("[TB] FAIL single_be: got %h want f", Rd_Byte_w_en); end
        tick();
        vectors++; if (Rd_Byte_w_en !== 4'h0) begin miscompares++; $display("[TB] FAIL single_once: got %h want 0", Rd_Byte_w_en); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL single_empty: got %b want 1", empty); end
    endtask

    task automatic test_partial_write();
        drive_request(1'b1, 5'd2, 32'h7F, 4'b1110);
        tick();
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
        tick();
        vectors++; if (Rd_Byte_w_en !== 4'b1110) begin miscompares++; $display("[TB] FAIL partial_be: got %h want e", Rd_Byte_w_en); end
        vectors++; if (Rd_in !== 32'h7F) begin miscompares++; $display("[TB] FAIL partial_data: got %h want 7f", Rd_in); end
        vectors++; if (Rd_addr !== 5'd2) begin miscompares++; $display("[TB] FAIL partial_addr: got %h want 2", Rd_addr); end
        tick();
    endtask

    task automatic test_filtering();
        q_addr = 5'd0;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive_request(1'b1, 5'd0, 32'hDEAD_BEEF, 4'hF);
            else        drive_request(1'b1, 5'd3, 32'h1234_5678, 4'h0);
            #1;
            vectors++; if (wb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL filter_ready%0d: got %b want 1", i, wb_ready); end
            tick();
            drive_request(1'b0, 5'd0, 32'h0, 4'h0);
            tick();
            vectors++; if (Rd_Byte_w_en !== 4'h0) begin miscompares++; $display("[TB] FAIL filter_be%0d: got %h want 0", i, Rd_Byte_w_en); end
            vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL filter_qhit%0d: got %b want 0", i, q_hit); end
            vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL filter_empty%0d: got %b want 1", i, empty); end
        end
    endtask

    task automatic test_back_to_back();
        wr_t reqs[6];
        int  sent = 0;
        int  emitted = 0;
        logic took;
        for (int i = 0; i < 6; i++) begin
            reqs[i].addr = 5'($urandom_range(1, 31));
            reqs[i].data = $urandom;
            reqs[i].be   = 4'($urandom_range(1, 15));
        end
        for (int cyc = 0; cyc < 40 && (sent < 6 || !exp_empty()); cyc++) begin
            if (sent < 6) drive_request(1'b1, reqs[sent].addr, reqs[sent].data, reqs[sent].be);
            else          drive_request(1'b0, 5'd0, 32'h0, 4'h0);
            #1;
            vectors++; if (wb_ready !== exp_ready()) begin miscompares++; $display("[TB] FAIL b2b_ready c%0d: got %b want %b", cyc, wb_ready, exp_ready()); end
            took = wb_valid && exp_ready();
            tick();
            if (took) sent++;
            if (Rd_Byte_w_en !== 4'h0) emitted++;
            vectors++;
            if (Rd_Byte_w_en !== out_w.be || Rd_addr !== out_w.addr || Rd_in !== out_w.data) begin
                miscompares++;
                $display("[TB] FAIL b2b_out c%0d: got %h/%h/%h want %h/%h/%h", cyc, Rd_addr, Rd_in, Rd_Byte_w_en, out_w.addr, out_w.data, out_w.be);
            end
        end
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
        vectors++; if (emitted != 6) begin miscompares++; $display("[TB] FAIL b2b_count: got %0d writes want 6", emitted); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_hazard();
        logic exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        q_addr = 5'd5;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc == 0)      drive_request(1'b1, 5'd3, 32'h3333_3333, 4'hF);
            else if (cyc == 1) drive_request(1'b1, 5'd5, 32'h5555_5555, 4'hF);
            else               drive_request(1'b0, 5'd0, 32'h0, 4'h0);
            tick();
            #1;
            vectors++; if (q_hit !== exp_seq[cyc]) begin miscompares++; $display("[TB] FAIL hazard_qhit c%0d: got %b want %b", cyc, q_hit, exp_seq[cyc]); end
        end
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
        q_addr = 5'd0;
    endtask

`ifdef REGFILE_WB_FWD_EN
    task automatic test_forwarding();
        drive_request(1'b1, 5'd5, 32'h1122_3344, 4'hF);
        tick();
        drive_request(1'b1, 5'd5, 32'h0000_00AA, 4'h1);
        tick();
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
        q_addr = 5'd5;
        #1;
        vectors++; if (q_data !== 32'h1122_33AA) begin miscompares++; $display("[TB] FAIL fwd_data: got %h want 112233aa", q_data); end
        vectors++; if (q_be !== 4'hF) begin miscompares++; $display("[TB] FAIL fwd_be: got %h want f", q_be); end
        tick();
        tick();
        q_addr = 5'd0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] fd;
        logic [3:0]  fb;
        for (int cyc = 0; cyc < 300; cyc++) begin
            drive_request($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                          $urandom,
                          ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
            q_addr = 5'($urandom_range(0, 7));
            #1;
            vectors++; if (wb_ready !== exp_ready()) begin miscompares++; $display("[TB] FAIL rand_ready c%0d: got %b want %b", cyc, wb_ready, exp_ready()); end
            vectors++; if (q_hit !== exp_hit(q_addr)) begin miscompares++; $display("[TB] FAIL rand_qhit c%0d: got %b want %b", cyc, q_hit, exp_hit(q_addr)); end
            vectors++; if (empty !== exp_empty()) begin miscompares++; $display("[TB] FAIL rand_empty c%0d: got %b want %b", cyc, empty, exp_empty()); end
`ifdef REGFILE_WB_FWD_EN
            exp_fwd(q_addr, fd, fb);
            vectors++; if (q_data !== fd || q_be !== fb) begin miscompares++; $display("[TB] FAIL rand_fwd c%0d: got %h/%h want %h/%h", cyc, q_data, q_be, fd, fb); end
`else
            exp_fwd(q_addr, fd, fb);
            vectors++; if (q_hit !== (fb != 4'h0)) begin miscompares++; $display("[TB] FAIL rand_cover c%0d: got %b want %b", cyc, q_hit, fb != 4'h0); end
`endif
            tick();
            vectors++;
            if (Rd_Byte_w_en !== out_w.be || Rd_addr !== out_w.addr || Rd_in !== out_w.data) begin
                miscompares++;
                $display("[TB] FAIL rand_out c%0d: got %h/%h/%h want %h/%h/%h", cyc, Rd_addr, Rd_in, Rd_Byte_w_en, out_w.addr, out_w.data, out_w.be);
            end
        end
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 0; i < 3; i++) begin
            drive_request(1'b1, 5'(i + 9), 32'hC0DE_0000 + i, 4'hF);
            tick();
        end
        q_addr = 5'd11;
        #2;
        rst = 1'b1;
        #1;
        mq.delete();
        out_w = '{addr: '0, data: '0, be: '0};
        vectors++; if (Rd_Byte_w_en !== 4'h0) begin miscompares++; $display("[TB] FAIL midrst_be: got %h want 0", Rd_Byte_w_en); end
        vectors++; if (wb_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_ready: got %b want 1", wb_ready); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_empty: got %b want 1", empty); end
        vectors++; if (q_hit !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_qhit: got %b want 0", q_hit); end
        drive_request(1'b0, 5'd0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            tick();
            vectors++; if (Rd_Byte_w_en !== 4'h0 || Rd_addr !== 5'd0) begin miscompares++; $display("[TB] FAIL midrst_stale c%0d: got %h/%h want 0/0", cyc, Rd_addr, Rd_Byte_w_en); end
        end
        q_addr = 5'd0;
    endtask

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single_write();
        test_partial_write();
        test_filtering();
        test_back_to_back();
        test_hazard();
`ifdef REGFILE_WB_FWD_EN
        test_forwarding();
`endif
        test_random();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side front end for the 32x32 MIPS register file write port (Rd_addr / Rd_in / Rd_Byte_w_en).
- Accepts byte-masked writeback requests from the execute and load units over a valid/ready handshake.
- Buffers requests in a small in-order FIFO and drains one per cycle into the register file.
- Flags pending writes to a queried register so the decode stage can stall on RAW hazards.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, register address width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  request valid.
- wb_ready  out  1  queue can accept; equals not-full.
- wb_addr  in  ADDR_WIDTH  destination register.
- wb_data  in  DATA_WIDTH  write data, already lane-aligned.
- wb_be  in  DATA_WIDTH/8  byte enables, active-high; bit i enables byte i.
- Rd_addr  out  ADDR_WIDTH  register file write address.
- Rd_in  out  DATA_WIDTH  register file write data.
- Rd_Byte_w_en  out  DATA_WIDTH/8  register file byte write enables, active-high; all zero means no write.
- q_addr  in  ADDR_WIDTH  hazard query address.
- q_hit  out  1  some queued or output-stage write targets q_addr.
- empty  out  1  FIFO and output stage both idle.

Behaviour:
- Reset (async, immediate): FIFO pointers and count = 0; Rd_addr = 0; Rd_in = 0; Rd_Byte_w_en = 0; wb_ready = 1; empty = 1; q_hit = 0.
- Accept: request pushed on an edge where wb_valid && wb_ready.
- Filtered requests: if wb_addr == 0 or wb_be == 0, the request is accepted (handshake completes) but not enqueued.
- Drain: each edge with count > 0, the head pops into the registered outputs Rd_addr/Rd_in/Rd_Byte_w_en.
- Idle output: each edge with count == 0, Rd_Byte_w_en <= 0. Rd_addr and Rd_in hold their previous values.
- Latency: request accepted at edge N into an empty queue is presented on the Rd_* outputs after edge N+1. The register file commits it at edge N+2.
- Throughput: one write per cycle. Order is strictly FIFO, so two writes to the same register apply in issue order.
- Simultaneous push and pop: allowed when full. Count is unchanged, so wb_ready stays 0 that cycle (registered not-full).
- Push into empty queue: takes the normal path through the FIFO; no bypass.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. A count register of log2(DEPTH)+1 bits distinguishes full from empty.
- Full: wb_ready = 0 and a request held valid is not taken. The requester must hold wb_valid and its payload stable until accepted.
- q_hit: combinational OR over valid FIFO entries and the output stage (when Rd_Byte_w_en != 0) of address equality with q_addr. q_addr == 0 always gives q_hit = 0.
- empty = (count == 0) && (Rd_Byte_w_en == 0).
- Reset mid-operation: all queued writes are discarded and no partial write is presented.

Optional Feature:
- Macro: REGFILE_WB_FWD_EN.
- Defined: adds outputs q_data (DATA_WIDTH) and q_be (DATA_WIDTH/8).
  - Sources are merged per byte lane, youngest FIFO entry first, then older entries, then the output stage.
  - q_be lane = 1 if any matching source enables that lane; q_data lane is taken from the youngest such source.
  - Lanes not covered by any source read 0.
  - The decode stage forwards from these instead of stalling.
- Undefined: the ports are absent and only q_hit is provided.

Decomposition:
- Package regfile_wb_pkg: DATA_WIDTH and ADDR_WIDTH defaults, BE_WIDTH = DATA_WIDTH/8, and a packed struct wb_entry_t {addr, data, be}.
- Sub-module regfile_wb_fifo: storage, pointers, count, full/empty, and per-entry valid vector exported for the hazard compare.
- The top level holds the output stage, filtering, hazard and forwarding logic.

Test Plan:
- Single write: reset, then wb_addr=1, wb_data=32'h48, wb_be=4'hF for one cycle. Expect Rd_addr=1, Rd_in=32'h48, Rd_Byte_w_en=4'hF for exactly one cycle two edges after the request; empty returns to 1.
- Partial write: wb_addr=2, wb_data=32'h7F, wb_be=4'b1110. Expect Rd_Byte_w_en=4'b1110 with data unmodified.
- Filtering: requests to register 0, and a request with wb_be=0. Expect handshake completes, Rd_Byte_w_en stays 0, q_hit stays 0 for q_addr=0.
- Backpressure: hold the Rd side stalled is impossible, so burst 6 back-to-back requests with DEPTH=4 and a full-detect check. Expect every request emerges in order, none lost, and wb_ready drops only while count==DEPTH.
- Hazard: queue writes to registers 3 and 5, set q_addr=5. Expect q_hit=1 until the reg 5 write leaves the output stage, then 0. With REGFILE_WB_FWD_EN, writes to reg 5 of 32'h11223344 (be=F) then 32'hAA (be=1) give q_data=32'h112233AA, q_be=4'hF.
- Reset mid-burst: assert rst with 3 entries queued. Expect Rd_Byte_w_en=0 and wb_ready=1 immediately, with no stale write after rst deasserts.
